// File: rtl/lzss_dec_unpack.sv
// ============================================================================
// Module   : lzss_dec_unpack
// Brief    : Splits an MSB-first packed LZSS bit stream into fixed-width codes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lzss_dec_unpack #(
  parameter  int pDataWidth     = 8,
  parameter  int pReferenceSize = 64,
  parameter  int pCodingSize    = 5,
  localparam int lpOffsetWidth  = $clog2(pReferenceSize),
  localparam int lpLengthWidth  = $clog2(pCodingSize) + 1,
  localparam int lpMatchWidth   = lpOffsetWidth + lpLengthWidth,
  localparam int pCodeWidth     = 1 + ((pDataWidth > lpMatchWidth) ? pDataWidth : lpMatchWidth)
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic                  i_valid,
  output logic                  ow_ready,
  input  logic [pDataWidth-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [pCodeWidth-1:0] o_code,
  output logic                  o_last
);

  localparam int lpMinBits  = 1 + ((pDataWidth < lpMatchWidth) ? pDataWidth : lpMatchWidth);
  localparam int lpBufWidth = pCodeWidth + pDataWidth;
  localparam int lpCntWidth = $clog2(lpBufWidth + 1);

  localparam logic [lpCntWidth-1:0] lpNeedLit   = lpCntWidth'(1 + pDataWidth);
  localparam logic [lpCntWidth-1:0] lpNeedMatch = lpCntWidth'(1 + lpMatchWidth);
  localparam logic [lpCntWidth-1:0] lpMinBitsC  = lpCntWidth'(lpMinBits);
  localparam logic [lpCntWidth-1:0] lpDataC     = lpCntWidth'(pDataWidth);
  localparam logic [lpCntWidth-1:0] lpAcceptMax = lpCntWidth'(lpBufWidth - pDataWidth);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [lpBufWidth-1:0]   acc_q, acc_d;
  logic [lpCntWidth-1:0]   count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic [pCodeWidth-1:0]   code_q, code_d;

  logic [lpCntWidth-1:0]   need;
  logic [lpCntWidth-1:0]   cnt_after;
  logic [lpBufWidth-1:0]   acc_shift;
  logic [lpBufWidth-1:0]   word_ext;
  logic [pCodeWidth-1:0]   code_w;
  logic                    extract;
  logic                    accept;

  always_comb begin
    need = '0;
    if (count_q != '0) begin
      need = acc_q[lpBufWidth-1] ? lpNeedMatch : lpNeedLit;
    end
  end

  assign extract  = (count_q != '0) && (count_q >= need) && (!valid_q || i_ready);
  // New stream words wait until the previous stream's final code is taken.
  assign ow_ready = (state_q == RUN) && (count_q <= lpAcceptMax) && !last_q;
  assign accept   = i_valid && ow_ready;
  assign word_ext = {i_data, {(lpBufWidth - pDataWidth){1'b0}}};

  always_comb begin
    code_w                 = '0;
    code_w[pCodeWidth-1]   = acc_q[lpBufWidth-1];
    if (acc_q[lpBufWidth-1]) begin
      code_w[lpOffsetWidth-1:0]             = acc_q[lpBufWidth-2 -: lpOffsetWidth];
      code_w[lpOffsetWidth +: lpLengthWidth] = acc_q[lpBufWidth-2-lpOffsetWidth -: lpLengthWidth];
    end else begin
      code_w[pDataWidth-1:0] = acc_q[lpBufWidth-2 -: pDataWidth];
    end
  end

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    last_d    = last_q;
    code_d    = code_q;
    cnt_after = extract ? (count_q - need) : count_q;
    acc_shift = extract ? (acc_q << need) : acc_q;
    acc_d     = acc_shift;
    count_d   = cnt_after;

    if (valid_q && i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    if (extract) begin
      valid_d = 1'b1;
      code_d  = code_w;
      last_d  = (state_q == FLUSH) && (cnt_after < lpMinBitsC);
    end

    if (accept) begin
      acc_d   = acc_shift | (word_ext >> cnt_after);
      count_d = cnt_after + lpDataC;
      if (i_last) begin
        state_d = FLUSH;
      end
    end

    // Leftover bits that cannot form a code are stream padding or a truncated code.
    if (state_q == FLUSH) begin
      if ((extract && (cnt_after < lpMinBitsC)) ||
          (!extract && ((count_q == '0) || (count_q < need)))) begin
        acc_d   = '0;
        count_d = '0;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_x) begin
      state_q <= RUN;
      acc_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      code_q  <= code_d;
    end
  end

  assign o_valid = valid_q;
  assign o_code  = code_q;
  assign o_last  = last_q;

endmodule

`default_nettype wire

// File: tb/tb_lzss_dec_unpack.sv
// ============================================================================
// Module   : tb_lzss_dec_unpack
// Brief    : Randomized self-checking bench for the LZSS bit-stream unpacker.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lzss_dec_unpack;

  logic        clk     = 1'b0;
  logic        rst_x   = 1'b1;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data  = 8'h00;
  logic        i_last  = 1'b0;
  logic        i_ready = 1'b0;
  logic        ow_ready;
  logic        o_valid;
  logic [10:0] o_code;
  logic        o_last;

  int tests  = 0;
  int errors = 0;

  logic [7:0]  wq[$];
  logic [10:0] eq[$];

  lzss_dec_unpack dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .i_valid  (i_valid),
    .ow_ready (ow_ready),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_code   (o_code),
    .o_last   (o_last)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected code word layout: flag at bit 10; literal in [7:0]; match = {1, len[3:0], off[5:0]}
  function automatic void add_lit(input logic [7:0] v);
    eq.push_back({3'b000, v});
  endfunction

  function automatic void add_match(input logic [5:0] off, input logic [3:0] len);
    eq.push_back({1'b1, len, off});
  endfunction

  // Serialise the expected codes as a bit list and cut it into zero-padded bytes
  function automatic void pack_words();
    bit bq[$];
    logic [10:0] c;
    logic [7:0]  v;
    wq.delete();
    foreach (eq[k]) begin
      c = eq[k];
      if (!c[10]) begin
        bq.push_back(1'b0);
        for (int b = 7; b >= 0; b--) bq.push_back(c[b]);
      end else begin
        bq.push_back(1'b1);
        for (int b = 5; b >= 0; b--) bq.push_back(c[b]);
        for (int b = 9; b >= 6; b--) bq.push_back(c[b]);
      end
    end
    while ((bq.size() % 8) != 0) bq.push_back(1'b0);
    for (int w = 0; w < bq.size() / 8; w++) begin
      v = 8'h00;
      for (int b = 0; b < 8; b++) v = {v[6:0], bq[w*8+b]};
      wq.push_back(v);
    end
  endfunction

  task automatic wait_valid(input string tag);
    for (int k = 0; k < 20 && !o_valid; k++) begin
      @(negedge clk);
      #1;
    end
    check_eq(tag, {31'd0, o_valid}, 32'd1);
  endtask

  task automatic run_stream(input int valid_pct, input int ready_pct,
                            input int stall_start, input int stall_len,
                            input bit want_ready_low);
    int          wi = 0;
    int          ci = 0;
    int          cyc = 0;
    bit          hold = 1'b0;
    logic [10:0] held_code = '0;
    logic        held_last = 1'b0;
    while (ci < eq.size() && cyc < 2000) begin
      @(negedge clk);
      i_valid = (wi < wq.size()) && ($urandom_range(99) < valid_pct);
      i_data  = i_valid ? wq[wi] : 8'($urandom);
      i_last  = i_valid && (wi == wq.size() - 1);
      i_ready = ($urandom_range(99) < ready_pct) &&
                !((cyc >= stall_start) && (cyc < stall_start + stall_len));
      #1;
      if (hold) begin
        check_eq("hold_valid", {31'd0, o_valid}, 32'd1);
        check_eq("hold_code", {21'd0, o_code}, {21'd0, held_code});
        check_eq("hold_last", {31'd0, o_last}, {31'd0, held_last});
      end
      if (want_ready_low && (cyc == stall_start + stall_len - 1))
        check_eq("stall_ow_ready", {31'd0, ow_ready}, 32'd0);
      if (o_valid && i_ready) begin
        check_eq("code", {21'd0, o_code}, {21'd0, eq[ci]});
        check_eq("last", {31'd0, o_last}, {31'd0, (ci == eq.size() - 1)});
        ci++;
      end
      hold      = o_valid && !i_ready;
      held_code = o_code;
      held_last = o_last;
      if (i_valid && ow_ready) wi++;
      cyc++;
    end
    if (cyc >= 2000) check_eq("stream_timeout", ci, eq.size());
    check_eq("words_used", wi, wq.size());
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("idle_valid", {31'd0, o_valid}, 32'd0);
    check_eq("idle_ow_ready", {31'd0, ow_ready}, 32'd1);
  endtask

  function automatic void mixed_stream();
    eq.delete();
    add_lit(8'h41);
    add_match(6'd3, 4'd4);
    add_lit(8'hFF);
    pack_words();
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("rst_last", {31'd0, o_last}, 32'd0);
    check_eq("rst_code", {21'd0, o_code}, 32'd0);
    check_eq("rst_ow_ready", {31'd0, ow_ready}, 32'd1);
    rst_x   = 1'b0;
    i_ready = 1'b1;

    // Single literal 0x41
    eq.delete();
    add_lit(8'h41);
    pack_words();
    run_stream(100, 100, 0, 0, 1'b0);

    // Single match offset 3 length 4
    eq.delete();
    add_match(6'd3, 4'd4);
    pack_words();
    run_stream(100, 100, 0, 0, 1'b0);

    // Mixed stream, free-flowing then with a 10-cycle downstream stall
    mixed_stream();
    run_stream(100, 100, 0, 0, 1'b0);
    mixed_stream();
    run_stream(100, 100, 0, 10, 1'b1);

    // Reset with buffered bits and a pending code
    mixed_stream();
    i_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = wq[w];
      i_last  = 1'b0;
    end
    @(negedge clk);
    i_valid = 1'b0;
    #1;
    wait_valid("pre_rst_valid");
    @(negedge clk);
    rst_x = 1'b1;
    @(negedge clk);
    #1;
    check_eq("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    check_eq("mid_rst_ow_ready", {31'd0, ow_ready}, 32'd1);
    rst_x = 1'b0;
    eq.delete();
    add_lit(8'h5A);
    pack_words();
    run_stream(100, 100, 0, 0, 1'b0);

    // Next stream offered while the previous final code is stalled
    eq.delete();
    add_lit(8'h41);
    pack_words();
    i_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      i_valid = 1'b1;
      i_data  = wq[w];
      i_last  = (w == 1);
    end
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'h20;
    i_last  = 1'b0;
    #1;
    wait_valid("b2b_valid");
    check_eq("b2b_code", {21'd0, o_code}, 32'h041);
    check_eq("b2b_last", {31'd0, o_last}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_eq("b2b_blocked", {31'd0, ow_ready}, 32'd0);
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(negedge clk);
    #1;
    check_eq("b2b_done_valid", {31'd0, o_valid}, 32'd0);
    mixed_stream();
    run_stream(100, 100, 0, 0, 1'b0);

    // Random streams with random flow control
    for (int s = 0; s < 30; s++) begin
      eq.delete();
      for (int k = 0; k < int'($urandom_range(6, 1)); k++) begin
        if ($urandom_range(1) == 0) add_lit(8'($urandom));
        else add_match(6'($urandom), 4'($urandom));
      end
      pack_words();
      run_stream(int'($urandom_range(100, 50)), int'($urandom_range(100, 40)),
                 int'($urandom_range(10)), int'($urandom_range(6)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
